// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug system-bus sequencer.
package dbg_bus_pkg;

  localparam int unsigned MAX_BURST = 256;
  localparam int unsigned BURST_W = 8;
  localparam logic [3:0] FULL_BYTE_ENABLES = 4'hF;

  typedef logic [BURST_W:0] words_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_WDATA,
    ST_RDATA,
    ST_END,
    ST_DONE
  } state_e;

  function automatic words_t burst_words(input logic [15:0] remaining);
    if (remaining > 16'(MAX_BURST)) return words_t'(MAX_BURST);
    return remaining[BURST_W:0];
  endfunction

endpackage

// File: rtl/dbg_bus_watchdog.sv
// Idle-cycle watchdog: load/kick clear the count, expire_o flags the
// TIMEOUT_CYCLES-th consecutive idle cycle.
module dbg_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic kick_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = !load_i && !kick_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d    = cnt_q + 1'b1;
    if (load_i || kick_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dbg_bus_sequencer.sv
// Debug command sequencer: splits word-count commands into system-bus burst
// transactions on a wired-OR bus, with watchdog and error handling.
module dbg_bus_sequencer
  import dbg_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        sb_clock_i,
  input  logic        sb_reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_address_i,
  input  logic [15:0] cmd_count_i,
  input  logic        wdata_valid_i,
  input  logic [31:0] wdata_i,
  output logic        wdata_ready_o,
  output logic        rdata_valid_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        error_o,
  output logic        sb_request_o,
  input  logic        sb_grant_i,
  output logic        sb_begin_transaction_o,
  output logic        sb_end_transaction_o,
  output logic        sb_data_valid_o,
  output logic [31:0] sb_address_data_o,
  output logic [3:0]  sb_byte_enables_o,
  output logic [7:0]  sb_burst_size_o,
  output logic        sb_read_n_write_o,
  input  logic [31:0] sb_address_data_i,
  input  logic        sb_data_valid_i,
  input  logic        sb_end_transaction_i,
  input  logic        sb_busy_i,
  input  logic        sb_error_i
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        end_drive_q, end_drive_d;
  words_t      beats_q, beats_d;
  words_t      beat_cnt_q, beat_cnt_d;
  words_t      acc_cnt_q, acc_cnt_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_q, hold_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_complete, rd_beat, wd_take, wdog_load, wdog_expire;

  // Progress terms live outside the FSM block so the watchdog's kick->expire
  // path does not form a loop through it.
  assign wr_complete = (state_q == ST_WDATA) && hold_valid_q && !sb_busy_i && !sb_error_i;
  assign rd_beat     = (state_q == ST_RDATA) && sb_data_valid_i && !sb_error_i &&
                       (beat_cnt_q < beats_q);
  assign wdog_load   = (state_q != ST_WDATA) && (state_q != ST_RDATA);
  assign wdata_ready_o = (state_q == ST_WDATA) && !sb_error_i && !wdog_expire &&
                         (acc_cnt_q < beats_q) && (!hold_valid_q || wr_complete);
  assign wd_take     = wdata_valid_i && wdata_ready_o;

  dbg_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (sb_clock_i),
    .rst_ni   (sb_reset_n_i),
    .load_i   (wdog_load),
    .kick_i   (wr_complete || rd_beat),
    .expire_o (wdog_expire)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    write_d       = write_q;
    err_d         = err_q;
    end_drive_d   = end_drive_q;
    beats_d       = beats_q;
    beat_cnt_d    = beat_cnt_q;
    acc_cnt_d     = acc_cnt_q;
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    rdata_valid_d = 1'b0;
    rdata_d       = rdata_q;
    case (state_q)
      ST_IDLE: if (cmd_valid_i && cmd_ready_q) begin
        addr_d      = cmd_address_i;
        remaining_d = cmd_count_i;
        write_d     = cmd_write_i;
        err_d       = (cmd_count_i == '0);
        state_d     = (cmd_count_i == '0) ? ST_DONE : ST_REQUEST;
      end
      ST_REQUEST: if (sb_grant_i) begin
        beats_d     = burst_words(remaining_q);
        remaining_d = remaining_q - 16'(burst_words(remaining_q));
        beat_cnt_d  = '0;
        acc_cnt_d   = '0;
        state_d     = ST_BEGIN;
      end
      ST_BEGIN: begin
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = write_q ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (sb_error_i) begin
          err_d        = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = ST_DONE;
        end else begin
          if (wr_complete) begin
            beat_cnt_d   = beat_cnt_q + 1'b1;
            hold_valid_d = 1'b0;
          end
          if (wd_take) begin
            hold_valid_d = 1'b1;
            hold_d       = wdata_i;
            acc_cnt_d    = acc_cnt_q + 1'b1;
          end
          if (wr_complete && (beat_cnt_d == beats_q)) begin
            end_drive_d = 1'b1;
            state_d     = ST_END;
          end else if (wdog_expire) begin
            err_d        = 1'b1;
            end_drive_d  = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = ST_END;
          end
        end
      end
      ST_RDATA: begin
        if (sb_error_i) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          if (rd_beat) begin
            beat_cnt_d    = beat_cnt_q + 1'b1;
            rdata_valid_d = 1'b1;
            rdata_d       = sb_address_data_i;
          end
          if (sb_end_transaction_i) begin
            if (beat_cnt_d != beats_q) err_d = 1'b1;
            state_d = ST_END;
          end else if (wdog_expire) begin
            err_d       = 1'b1;
            end_drive_d = 1'b1;
            state_d     = ST_END;
          end
        end
      end
      ST_END: begin
        if (sb_error_i) err_d = 1'b1;
        end_drive_d = 1'b0;
        addr_d      = addr_q + {21'b0, beats_q, 2'b00};
        state_d     = (err_d || (remaining_q == '0)) ? ST_DONE : ST_REQUEST;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
    if (!sb_reset_n_i) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      end_drive_q   <= 1'b0;
      beats_q       <= '0;
      beat_cnt_q    <= '0;
      acc_cnt_q     <= '0;
      hold_valid_q  <= 1'b0;
      hold_q        <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      write_q       <= write_d;
      err_q         <= err_d;
      end_drive_q   <= end_drive_d;
      beats_q       <= beats_d;
      beat_cnt_q    <= beat_cnt_d;
      acc_cnt_q     <= acc_cnt_d;
      hold_valid_q  <= hold_valid_d;
      hold_q        <= hold_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
    end
  end

  // Bus outputs decode registered state only; every field is zero unless owned.
  always_comb begin
    sb_request_o           = (state_q == ST_REQUEST);
    sb_begin_transaction_o = (state_q == ST_BEGIN);
    sb_end_transaction_o   = (state_q == ST_END) && end_drive_q;
    sb_data_valid_o        = (state_q == ST_WDATA) && hold_valid_q;
    sb_address_data_o      = '0;
    if (state_q == ST_BEGIN) sb_address_data_o = addr_q;
    else if (sb_data_valid_o) sb_address_data_o = hold_q;
    sb_byte_enables_o = (state_q == ST_BEGIN) ? FULL_BYTE_ENABLES : '0;
    sb_burst_size_o   = (state_q == ST_BEGIN) ? BURST_W'(beats_q - 1'b1) : '0;
    sb_read_n_write_o = (state_q == ST_BEGIN) && !write_q;
    done_o            = (state_q == ST_DONE);
    error_o           = (state_q == ST_DONE) && err_q;
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rdata_valid_o = rdata_valid_q;
  assign rdata_o       = rdata_q;

endmodule

// File: tb/tb_dbg_bus_sequencer.sv
// Directed bench for dbg_bus_sequencer with expected-value queues for read
// data and transaction headers.
module tb_dbg_bus_sequencer;

  logic        sb_clock_i = 1'b0;
  logic        sb_reset_n_i = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
  logic [31:0] cmd_address_i = '0;
  logic [15:0] cmd_count_i = '0;
  logic        cmd_ready_o;
  logic        wdata_valid_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic        wdata_ready_o, rdata_valid_o, done_o, error_o;
  logic [31:0] rdata_o;
  logic        sb_request_o, sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o;
  logic [31:0] sb_address_data_o;
  logic [3:0]  sb_byte_enables_o;
  logic [7:0]  sb_burst_size_o;
  logic        sb_read_n_write_o;
  logic        sb_grant_i = 1'b0, sb_data_valid_i = 1'b0, sb_end_transaction_i = 1'b0;
  logic        sb_busy_i = 1'b0, sb_error_i = 1'b0;
  logic [31:0] sb_address_data_i = '0;

  dbg_bus_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .sb_clock_i(sb_clock_i), .sb_reset_n_i(sb_reset_n_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_address_i(cmd_address_i), .cmd_count_i(cmd_count_i),
    .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
    .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .done_o(done_o), .error_o(error_o),
    .sb_request_o(sb_request_o), .sb_grant_i(sb_grant_i),
    .sb_begin_transaction_o(sb_begin_transaction_o), .sb_end_transaction_o(sb_end_transaction_o),
    .sb_data_valid_o(sb_data_valid_o), .sb_address_data_o(sb_address_data_o),
    .sb_byte_enables_o(sb_byte_enables_o), .sb_burst_size_o(sb_burst_size_o),
    .sb_read_n_write_o(sb_read_n_write_o), .sb_address_data_i(sb_address_data_i),
    .sb_data_valid_i(sb_data_valid_i), .sb_end_transaction_i(sb_end_transaction_i),
    .sb_busy_i(sb_busy_i), .sb_error_i(sb_error_i)
  );

  always #5 sb_clock_i = ~sb_clock_i;

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  logic [31:0] exp_rd[$];
  logic [44:0] exp_begin[$];
  logic [31:0] wr_words[$];
  int   wr_idx = 0;
  bit   cmd_fire, wd_fire, done_seen;
  logic err_seen;
  int   n_rd, n_end, n_dv, n_dv_ok, n;
  logic [31:0] dv_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit bus_active();
    return sb_request_o || sb_begin_transaction_o || sb_end_transaction_o || sb_data_valid_o ||
           (sb_address_data_o != '0) || (sb_byte_enables_o != '0) ||
           (sb_burst_size_o != '0) || sb_read_n_write_o;
  endfunction

  // One clock: handshakes sampled before the edge, outputs observed after it.
  task automatic tick();
    @(negedge sb_clock_i);
    cmd_fire = cmd_valid_i && cmd_ready_o;
    wd_fire  = wdata_valid_i && wdata_ready_o;
    @(posedge sb_clock_i);
    #1;
    if (rdata_valid_o) begin
      n_rd++;
      check("rdata_expected_pending", 64'(exp_rd.size() != 0), 64'(1));
      if (exp_rd.size() != 0) check("rdata_value", 64'(rdata_o), 64'(exp_rd.pop_front()));
    end
    if (sb_begin_transaction_o) begin
      check("begin_expected_pending", 64'(exp_begin.size() != 0), 64'(1));
      if (exp_begin.size() != 0)
        check("begin_header", 64'({sb_address_data_o, sb_burst_size_o, sb_byte_enables_o,
                                   sb_read_n_write_o}), 64'(exp_begin.pop_front()));
    end
    if (sb_end_transaction_o) n_end++;
    if (sb_data_valid_o) begin
      n_dv++;
      if (sb_address_data_o == dv_exp) n_dv_ok++;
    end
    if (done_o) begin
      done_seen = 1'b1;
      err_seen  = error_o;
    end
    if (wd_fire) wr_idx++;
    wdata_valid_i = (wr_idx < wr_words.size());
    wdata_i       = wdata_valid_i ? wr_words[wr_idx] : '0;
  endtask

  task automatic start_test();
    n_rd = 0; n_end = 0; n_dv = 0; n_dv_ok = 0;
    done_seen = 1'b0; err_seen = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input int cnt);
    wr_words.delete();
    if (cnt > 0) wr_words.push_back(w0);
    if (cnt > 1) wr_words.push_back(w1);
    if (cnt > 2) wr_words.push_back(w2);
    if (cnt > 3) wr_words.push_back(w3);
    wr_idx = 0;
    wdata_valid_i = (cnt > 0);
    wdata_i = w0;
  endtask

  task automatic clear_words();
    wr_words.delete();
    wr_idx = 0;
    wdata_valid_i = 1'b0;
    wdata_i = '0;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [15:0] cnt);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_address_i = addr; cmd_count_i = cnt;
    cmd_fire = 1'b0;
    for (int i = 0; i < 20 && !cmd_fire; i++) tick();
    check("cmd_accepted", 64'(cmd_fire), 64'(1));
    cmd_valid_i = 1'b0;
  endtask

  task automatic grant_after(input int cycles);
    int held = 0;
    for (int i = 0; i < 20 && !sb_request_o; i++) tick();
    check("request_seen", 64'(sb_request_o), 64'(1));
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (sb_request_o) held++;
    end
    if (cycles > 0) check("request_held", 64'(held), 64'(cycles));
    sb_grant_i = 1'b1;
    tick();
    sb_grant_i = 1'b0;
    check("begin_after_grant", 64'(sb_begin_transaction_o), 64'(1));
  endtask

  // Slave returns n_send beats with end on the last; only n_exp are in-burst.
  task automatic read_beats(input int n_send, input int n_exp, input logic [31:0] base);
    tick();
    for (int i = 0; i < n_send; i++) begin
      sb_data_valid_i      = 1'b1;
      sb_address_data_i    = base + 32'(i);
      sb_end_transaction_i = (i == n_send - 1);
      if (i < n_exp) exp_rd.push_back(base + 32'(i));
      tick();
    end
    sb_data_valid_i = 1'b0; sb_end_transaction_i = 1'b0; sb_address_data_i = '0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    for (int i = 0; i < 60 && !done_seen; i++) tick();
    check({tag, "_done"}, 64'(done_seen), 64'(1));
    check({tag, "_error"}, 64'(err_seen), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset held from time 0; outputs must be quiet.
    #8;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
    check("rst_bus_quiet", 64'(bus_active()), 64'(0));
    check("rst_done", 64'({done_o, error_o, rdata_valid_o, wdata_ready_o}), 64'(0));
    #4 sb_reset_n_i = 1'b1;
    @(posedge sb_clock_i); #1;
    check("rst_ready_first_edge", 64'(cmd_ready_o), 64'(1));

    // Read 1 word, grant after 3 request cycles.
    start_test();
    exp_begin.push_back({32'h0000_1000, 8'd0, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_1000, 16'd1);
    grant_after(3);
    read_beats(1, 1, 32'hDEAD_BEEF);
    wait_done("rd1", 1'b0);
    check("rd1_pulses", 64'(n_rd), 64'(1));

    // Zero-length command: done with error the next cycle, bus untouched.
    start_test();
    send_cmd(1'b0, 32'h0000_9000, 16'd0);
    check("zero_done", 64'({done_o, error_o}), 64'(2'b11));
    check("zero_bus_quiet", 64'(bus_active()), 64'(0));

    // Write 1 word with busy held for 5 beat cycles.
    start_test();
    exp_begin.push_back({32'h0000_3000, 8'd0, 4'hF, 1'b0});
    dv_exp = 32'hDEAD_BEEF;
    load_words(32'hDEAD_BEEF, '0, '0, '0, 1);
    send_cmd(1'b1, 32'h0000_3000, 16'd1);
    grant_after(0);
    sb_busy_i = 1'b1;
    for (int i = 0; i < 10 && !sb_data_valid_o; i++) tick();
    for (int i = 0; i < 5; i++) tick();
    sb_busy_i = 1'b0;
    tick();
    check("wr1_end_now", 64'(sb_end_transaction_o), 64'(1));
    wait_done("wr1", 1'b0);
    check("wr1_dv_cycles", 64'(n_dv), 64'(6));
    check("wr1_dv_stable", 64'(n_dv_ok), 64'(6));
    check("wr1_end_count", 64'(n_end), 64'(1));
    clear_words();

    // Read 300 words: 256-word burst then 44-word burst at +0x400.
    start_test();
    exp_begin.push_back({32'h0000_2000, 8'd255, 4'hF, 1'b1});
    exp_begin.push_back({32'h0000_2400, 8'd43, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_2000, 16'd300);
    grant_after(0);
    read_beats(256, 256, 32'hA000_0000);
    grant_after(1);
    read_beats(44, 44, 32'hB000_0000);
    wait_done("rd300", 1'b0);
    check("rd300_pulses", 64'(n_rd), 64'(300));
    check("rd300_no_end_driven", 64'(n_end), 64'(0));

    // Write 4 words, bus error while beat 2 completes.
    start_test();
    exp_begin.push_back({32'h0000_4000, 8'd3, 4'hF, 1'b0});
    load_words(32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000, 4);
    send_cmd(1'b1, 32'h0000_4000, 16'd4);
    grant_after(0);
    for (int i = 0; i < 20 && !(sb_data_valid_o && sb_address_data_o == 32'h2222_0000); i++)
      tick();
    check("werr_beat2_on_bus", 64'(sb_address_data_o), 64'(32'h2222_0000));
    sb_error_i = 1'b1;
    tick();
    sb_error_i = 1'b0;
    check("werr_bus_quiet", 64'(bus_active()), 64'(0));
    check("werr_done", 64'({done_o, error_o}), 64'(2'b11));
    check("werr_no_end", 64'(n_end), 64'(0));
    clear_words();

    // Read 2 words, slave silent: 1 cycle into RDATA plus 16 idle cycles.
    start_test();
    exp_begin.push_back({32'h0000_5000, 8'd1, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_5000, 16'd2);
    grant_after(0);
    n = 0;
    while (!sb_end_transaction_o && n < 40) begin
      tick();
      n++;
    end
    check("tmo_idle_cycles", 64'(n - 1), 64'(16));
    wait_done("tmo", 1'b1);
    check("tmo_end_count", 64'(n_end), 64'(1));
    check("tmo_no_rdata", 64'(n_rd), 64'(0));

    // Read 3 words, slave sends 4: extra beat dropped.
    start_test();
    exp_begin.push_back({32'h0000_6000, 8'd2, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_6000, 16'd3);
    grant_after(0);
    read_beats(4, 3, 32'h0000_6600);
    wait_done("rdover", 1'b0);
    check("rdover_pulses", 64'(n_rd), 64'(3));

    // Read 3 words, slave ends after 2: error.
    start_test();
    exp_begin.push_back({32'h0000_7000, 8'd2, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_7000, 16'd3);
    grant_after(0);
    read_beats(2, 2, 32'h0000_7700);
    wait_done("rdshort", 1'b1);
    check("rdshort_pulses", 64'(n_rd), 64'(2));

    // Reset mid-write, then a normal read.
    start_test();
    exp_begin.push_back({32'h0000_8000, 8'd1, 4'hF, 1'b0});
    load_words(32'hCAFE_0001, 32'hCAFE_0002, '0, '0, 2);
    send_cmd(1'b1, 32'h0000_8000, 16'd2);
    grant_after(0);
    sb_busy_i = 1'b1;
    for (int i = 0; i < 10 && !sb_data_valid_o; i++) tick();
    check("mrst_in_wdata", 64'(sb_data_valid_o), 64'(1));
    #2 sb_reset_n_i = 1'b0;
    #1;
    check("mrst_bus_quiet", 64'(bus_active()), 64'(0));
    check("mrst_outputs", 64'({cmd_ready_o, done_o, error_o, rdata_valid_o, wdata_ready_o}),
          64'(0));
    check("mrst_no_end", 64'(n_end), 64'(0));
    clear_words();
    sb_busy_i = 1'b0;
    #1 sb_reset_n_i = 1'b1;
    @(posedge sb_clock_i); #1;
    check("mrst_ready_first_edge", 64'(cmd_ready_o), 64'(1));
    start_test();
    exp_begin.push_back({32'h0000_8800, 8'd0, 4'hF, 1'b1});
    send_cmd(1'b0, 32'h0000_8800, 16'd1);
    grant_after(2);
    read_beats(1, 1, 32'hA5A5_0000);
    wait_done("postrst", 1'b0);
    check("postrst_pulses", 64'(n_rd), 64'(1));

    check("rdata_queue_drained", 64'(exp_rd.size()), 64'(0));
    check("begin_queue_drained", 64'(exp_begin.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dbg_bus_sequencer.md
DBG_BUS_SEQUENCER -- requirements
Module: dbg_bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024; idle-bus cycles tolerated mid-transaction before abort.
REQ-002 SHALL have ports: sb_clock_i  in  1  system bus clock; sb_reset_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: cmd_valid_i in 1, cmd_ready_o out 1, cmd_write_i in 1, cmd_address_i in 32, cmd_count_i in 16; command handshake, word address, words to move.
REQ-004 SHALL have ports: wdata_valid_i in 1, wdata_i in 32, wdata_ready_o out 1 (write words); rdata_valid_o out 1, rdata_o out 32 (read words).
REQ-005 SHALL have ports: done_o out 1 (command finished pulse), error_o out 1 (valid with done_o).
REQ-006 SHALL have bus ports: sb_request_o out 1, sb_grant_i in 1, sb_begin_transaction_o out 1, sb_end_transaction_o out 1, sb_data_valid_o out 1, sb_address_data_o out 32, sb_byte_enables_o out 4, sb_burst_size_o out 8, sb_read_n_write_o out 1.
REQ-007 SHALL have bus inputs: sb_address_data_i 32, sb_data_valid_i 1, sb_end_transaction_i 1, sb_busy_i 1, sb_error_i 1.

Function
REQ-008 SHALL drive every sb_*_o as all-zero in any cycle it is not actively driving it (wired-OR bus).
REQ-009 SHALL accept a command when cmd_valid_i && cmd_ready_o; cmd_ready_o high only in IDLE; cmd_count_i==0 completes next cycle with done_o=1, error_o=1, no bus activity.
REQ-010 SHALL split a command into transactions of min(remaining,256) words; address advances by 4*words per transaction; burst_size_o = words-1.
REQ-011 SHALL use FSM IDLE -> REQUEST -> BEGIN -> (WDATA | RDATA) -> END -> (REQUEST if words remain | DONE) -> IDLE.
REQ-012 REQUEST: sb_request_o=1 until sb_grant_i sampled high; BEGIN the following cycle.
REQ-013 BEGIN: one cycle of sb_begin_transaction_o=1 with address, burst_size, byte_enables=4'hF, read_n_write=~cmd_write_i.
REQ-014 WDATA: a beat is driven (sb_data_valid_o=1, data) only when a write word is held; beat completes on a cycle with sb_busy_i=0; while sb_busy_i=1 the same beat is held; wdata_ready_o=1 only when the holding register is empty or completing.
REQ-015 END (write): sb_end_transaction_o=1 for exactly one cycle after the last beat completes.
REQ-016 RDATA: each cycle with sb_data_valid_i=1 SHALL produce rdata_valid_o=1, rdata_o=sb_address_data_i the next cycle (latency 1); transaction ends on sb_end_transaction_i, which may arrive in or after the last beat cycle.
REQ-017 Read beats beyond burst length SHALL be discarded; sb_end_transaction_i before all beats SHALL end the command with error.
REQ-018 sb_error_i in BEGIN/WDATA/RDATA/END SHALL drop all bus outputs next cycle, drive no end_transaction, and go to DONE with error.
REQ-019 A watchdog SHALL count cycles without beat progress in WDATA/RDATA; at TIMEOUT_CYCLES the block drives one cycle of sb_end_transaction_o and finishes with error.
REQ-020 DONE: one cycle, done_o=1, error_o = sticky error of the command; remaining words abandoned on error.
REQ-021 sb_error_i and a completing beat in the same cycle: error wins, beat not counted.

Reset
REQ-022 Asserting sb_reset_n_i SHALL immediately force IDLE, all outputs 0, counters and watchdog 0, including mid-transaction; no end_transaction is emitted.
REQ-023 After deassertion, cmd_ready_o SHALL be 1 on the first clock edge.

Structure
REQ-024 A shared package dbg_bus_pkg SHALL hold the FSM state enum, MAX_BURST=256, BURST_W=8, FULL_BYTE_ENABLES=4'hF.
REQ-025 The watchdog SHALL be sub-module dbg_bus_watchdog (load, kick, expire); all else in one module.

Verification
REQ-026 Read 1 word at 0x1000, grant after 3 cycles, slave returns 0xDEADBEEF -> begin with addr 0x1000, burst 0, rdata_o=0xDEADBEEF, done_o, error_o=0.
REQ-027 Write 1 word 0xDEADBEEF, sb_busy_i high 5 cycles -> data_valid held 6 cycles stable, one end_transaction, done_o, error_o=0.
REQ-028 Read 300 words at 0x2000 -> two transactions: 0x2000 burst 255, 0x2400 burst 43; 300 rdata pulses.
REQ-029 Write 4 words, sb_error_i on beat 2 -> outputs zero next cycle, no end_transaction, done_o with error_o=1.
REQ-030 Read 2 words, slave silent after grant, TIMEOUT_CYCLES=16 -> end_transaction after 16 cycles, error_o=1.
REQ-031 Reset asserted in WDATA -> all bus outputs 0 at once; next command executes normally.
